orientation_moment_stream: RTL

//  Streaming intensity-centroid moment engine for ORB orientation. Takes one
//  (2R+1)-pixel image column per valid beat and slides a (2R+1)x(2R+1) patch

---
 rtl/orient_pkg.sv | 35 +++
 rtl/orient_col_reduce.sv | 58 +++++
 rtl/orientation_moment_stream.sv | 137 +++++++++++++
 3 files changed

// File: rtl/orient_pkg.sv
// Shared sizing helpers for the ORB orientation moment engine.
// Widths are derived from pixel width and patch radius so sub-modules stay in step.
package orient_pkg;

    localparam int ORIENT_R_DEF = 3;
    localparam int N            = 2*ORIENT_R_DEF + 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cs_w(input int pix_w, input int r);
        return pix_w + clog2(2*r + 1);
    endfunction

    function automatic int mom_w(input int pix_w, input int r);
        return pix_w + clog2((2*r + 1)*r*(r + 1)/2 + 1) + 1;
    endfunction

    // Multiply by a small elaboration-time constant using shifted adds only.
    function automatic logic [31:0] mul_small(input logic [31:0] v, input int k);
        logic [31:0] acc;
        acc = '0;
        for (int b = 0; b < 8; b++) begin
            if (k[b]) acc = acc + (v << b);
        end
        return acc;
    endfunction

endpackage

// File: rtl/orient_col_reduce.sv
// Stage 1: reduce one incoming column to its pixel sum and its dy-weighted sum.
// The sol flag travels with the column so stage 2 clears state in step with it.
module orient_col_reduce
    import orient_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int RADIUS = 3,
    parameter int CS_W   = cs_w(8, 3),
    parameter int MOM_W  = mom_w(8, 3)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic                          i_sol,
    input  logic [(2*RADIUS+1)*PIX_W-1:0] i_col,
    output logic                          o_valid,
    output logic                          o_sol,
    output logic [CS_W-1:0]               o_c,
    output logic signed [MOM_W-1:0]       o_y
);

    localparam int NS = 2*RADIUS + 1;

    logic [CS_W-1:0]         w_c;
    logic signed [MOM_W-1:0] w_y;
    logic [31:0]             w_pix;

    always_comb begin
        w_c   = '0;
        w_y   = '0;
        w_pix = '0;
        for (int r = 0; r < NS; r++) begin
            w_pix = 32'(i_col[r*PIX_W +: PIX_W]);
            w_c   = w_c + CS_W'(w_pix);
            if (r > RADIUS)
                w_y = w_y + MOM_W'(mul_small(w_pix, r - RADIUS));
            else if (r < RADIUS)
                w_y = w_y - MOM_W'(mul_small(w_pix, RADIUS - r));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_sol   <= 1'b0;
            o_c     <= '0;
            o_y     <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_sol <= i_sol;
                o_c   <= w_c;
                o_y   <= w_y;
            end
        end
    end

endmodule

// File: rtl/orientation_moment_stream.sv
// Column-incremental m10/m01 engine: keeps the last N column sums and updates
// the patch moments in O(1) per column instead of re-summing the whole patch.
module orientation_moment_stream
    import orient_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int RADIUS = 3,
    parameter int WIDTH  = 640
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic                                       i_valid,
    input  logic                                       i_sol,
    input  logic [(2*RADIUS+1)*PIX_W-1:0]              i_col,
    output logic                                       o_valid,
    output logic signed [mom_w(PIX_W, RADIUS)-1:0]     o_mx,
    output logic signed [mom_w(PIX_W, RADIUS)-1:0]     o_my,
    output logic [clog2(WIDTH)-1:0]                    o_xpos,
    output logic                                       o_overrun
);

    localparam int NS    = 2*RADIUS + 1;
    localparam int CS_W  = cs_w(PIX_W, RADIUS);
    localparam int MOM_W = mom_w(PIX_W, RADIUS);
    localparam int XW    = clog2(WIDTH);
    localparam int NW    = clog2(WIDTH + 1);

    logic                    w_s1_valid;
    logic                    w_s1_sol;
    logic [CS_W-1:0]         w_s1_c;
    logic signed [MOM_W-1:0] w_s1_y;

    orient_col_reduce #(
        .PIX_W  (PIX_W),
        .RADIUS (RADIUS),
        .CS_W   (CS_W),
        .MOM_W  (MOM_W)
    ) u_col_reduce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_sol   (i_sol),
        .i_col   (i_col),
        .o_valid (w_s1_valid),
        .o_sol   (w_s1_sol),
        .o_c     (w_s1_c),
        .o_y     (w_s1_y)
    );

    logic [CS_W-1:0]         r_hist_c [NS];
    logic signed [MOM_W-1:0] r_hist_y [NS];
    logic signed [MOM_W-1:0] r_s;
    logic signed [MOM_W-1:0] r_m10;
    logic signed [MOM_W-1:0] r_m01;
    logic [NW-1:0]           r_n;
    logic                    r_in_line;

    logic                    w_take;
    logic                    w_emit;
    logic [CS_W-1:0]         w_c_out;
    logic signed [MOM_W-1:0] w_y_out;
    logic signed [MOM_W-1:0] w_s_base;
    logic signed [MOM_W-1:0] w_m10_base;
    logic signed [MOM_W-1:0] w_m01_base;
    logic [NW-1:0]           w_n_base;
    logic                    w_ovr_base;
    logic signed [MOM_W-1:0] w_s_nx;
    logic signed [MOM_W-1:0] w_m10_nx;
    logic signed [MOM_W-1:0] w_m01_nx;
    logic [NW-1:0]           w_n_nx;
    logic                    w_ovr_nx;
    logic [XW-1:0]           w_xpos;

    // A start-of-line column sees an all-zero history, so partial windows stay exact.
    always_comb begin
        w_take     = w_s1_valid && (w_s1_sol || r_in_line);
        w_c_out    = w_s1_sol ? '0   : r_hist_c[NS-1];
        w_y_out    = w_s1_sol ? '0   : r_hist_y[NS-1];
        w_s_base   = w_s1_sol ? '0   : r_s;
        w_m10_base = w_s1_sol ? '0   : r_m10;
        w_m01_base = w_s1_sol ? '0   : r_m01;
        w_n_base   = w_s1_sol ? '0   : r_n;
        w_ovr_base = w_s1_sol ? 1'b0 : o_overrun;

        w_m10_nx = w_m10_base - w_s_base
                 + MOM_W'(mul_small(32'(w_c_out), RADIUS + 1))
                 + MOM_W'(mul_small(32'(w_s1_c), RADIUS));
        w_s_nx   = w_s_base - MOM_W'(w_c_out) + MOM_W'(w_s1_c);
        w_m01_nx = w_m01_base - w_y_out + w_s1_y;

        w_n_nx   = (w_n_base == NW'(WIDTH)) ? w_n_base : w_n_base + NW'(1);
        w_ovr_nx = w_ovr_base || (w_n_base == NW'(WIDTH));
        w_emit   = w_take && (w_n_nx >= NW'(NS)) && !w_ovr_nx;
        w_xpos   = XW'(w_n_nx - NW'(RADIUS + 1));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NS; k++) begin
                r_hist_c[k] <= '0;
                r_hist_y[k] <= '0;
            end
            r_s       <= '0;
            r_m10     <= '0;
            r_m01     <= '0;
            r_n       <= '0;
            r_in_line <= 1'b0;
            o_valid   <= 1'b0;
            o_mx      <= '0;
            o_my      <= '0;
            o_xpos    <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_valid <= w_emit;
            if (w_take) begin
                for (int k = NS-1; k > 0; k--) begin
                    r_hist_c[k] <= w_s1_sol ? '0 : r_hist_c[k-1];
                    r_hist_y[k] <= w_s1_sol ? '0 : r_hist_y[k-1];
                end
                r_hist_c[0] <= w_s1_c;
                r_hist_y[0] <= w_s1_y;
                r_s         <= w_s_nx;
                r_m10       <= w_m10_nx;
                r_m01       <= w_m01_nx;
                r_n         <= w_n_nx;
                r_in_line   <= 1'b1;
                o_overrun   <= w_ovr_nx;
                if (w_emit) begin
                    o_mx   <= w_m10_nx;
                    o_my   <= w_m01_nx;
                    o_xpos <= w_xpos;
                end
            end
        end
    end

endmodule
